// File: rtl/chip8_fetch_sequencer.sv
// Purpose : owns the Chip8 PC, fetches the big-endian opcode and sequences the CPU execute stages.
// Latency : 3 cycles from FETCH_HI to stage=1; n execute cycles; 1 UPDATE_PC cycle.
// Backpress: run=0 idles in FETCH_HI; a keypress halt freezes stage; instr_done ends execute.
//
// Ports:
//   cpu_clk, reset        - single clock, synchronous active-high reset
//   run                   - permit new fetches (current instruction always completes)
//   mem_addr/mem_readdata - fetch port; read data arrives one cycle after the address
//   instruction, stage    - opcode {hi,lo} and execute stage count (0 outside execute)
//   instr_done, pc_src,
//   PC_writedata          - CPU completion and PC update request (0:+2 1:+4 2:load 3:hold)
//   PC_readdata           - address of the executing instruction
//   halt_for_keypress,
//   key_pressed           - stage freezes while the CPU waits for a key
//   fault                 - sticky watchdog trip
//
// Optional feature: define CHIP8_FETCH_WATCHDOG_EN to enable the execute-length
// watchdog bounded by MAX_STAGES. Without it, fault is constant 0.

module chip8_fetch_sequencer #(
    parameter logic [11:0] PC_RESET   = 12'h200,
    parameter logic [31:0] MAX_STAGES = 32'd64
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        run,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_readdata,
    output logic [15:0] instruction,
    output logic [31:0] stage,
    input  logic        instr_done,
    input  logic [1:0]  pc_src,
    input  logic [11:0] PC_writedata,
    output logic [11:0] PC_readdata,
    input  logic        halt_for_keypress,
    input  logic        key_pressed,
    output logic        fault
);

    typedef enum logic [2:0] {
        FETCH_HI,
        FETCH_LO,
        LATCH,
        EXECUTE,
        UPDATE_PC
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [11:0] pc_q;
    logic [7:0]  hi_q;
    logic [15:0] instr_q;
    logic [31:0] stage_q;
    logic [1:0]  src_q;
    logic [11:0] target_q;
    logic        fault_q;

    logic        stall;
    logic        wd_trip;
    logic [11:0] next_pc;

    // A pending keypress freezes the stage count; instr_done still wins.
    assign stall = halt_for_keypress && !key_pressed;

`ifdef CHIP8_FETCH_WATCHDOG_EN
    // Runaway execute: retire the instruction as a plain +2 and flag it.
    // A keypress wait is legitimate and never trips.
    assign wd_trip = (state_q == EXECUTE) && !instr_done && !stall &&
                     (stage_q >= MAX_STAGES);
`else
    logic unused_max_stages;
    assign unused_max_stages = ^MAX_STAGES;
    assign wd_trip           = 1'b0;
`endif

    // PC arithmetic wraps naturally at 12 bits.
    always_comb begin
        next_pc = pc_q;
        case (src_q)
            2'd0:    next_pc = pc_q + 12'd2;
            2'd1:    next_pc = pc_q + 12'd4;
            2'd2:    next_pc = target_q;
            default: next_pc = pc_q;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q <= FETCH_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the fetch address. The memory port is released (address 0)
    // outside the two fetch states so the CPU can use it during execute.
    always_comb begin
        state_d  = state_q;
        mem_addr = 12'h000;
        case (state_q)
            FETCH_HI: begin
                if (run) begin
                    mem_addr = pc_q;
                    state_d  = FETCH_LO;
                end
            end
            FETCH_LO: begin
                mem_addr = pc_q + 12'd1;
                state_d  = LATCH;
            end
            LATCH: begin
                state_d = EXECUTE;
            end
            EXECUTE: begin
                if (instr_done || wd_trip) begin
                    state_d = UPDATE_PC;
                end
            end
            UPDATE_PC: begin
                state_d = FETCH_HI;
            end
            default: begin
                state_d = FETCH_HI;
            end
        endcase
        if (reset) begin
            mem_addr = 12'h000;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            pc_q     <= PC_RESET;
            hi_q     <= 8'h00;
            instr_q  <= 16'h0000;
            stage_q  <= 32'd0;
            src_q    <= 2'd0;
            target_q <= 12'h000;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH_LO: begin
                    // Data for the FETCH_HI address is on the bus now.
                    hi_q <= mem_readdata;
                end
                LATCH: begin
                    instr_q <= {hi_q, mem_readdata};
                    stage_q <= 32'd1;
                end
                EXECUTE: begin
                    if (instr_done) begin
                        src_q    <= pc_src;
                        target_q <= PC_writedata;
                    end else if (wd_trip) begin
                        src_q   <= 2'd0;
                        fault_q <= 1'b1;
                    end else if (!stall && (stage_q != 32'hFFFF_FFFF)) begin
                        stage_q <= stage_q + 32'd1;
                    end
                end
                UPDATE_PC: begin
                    pc_q    <= next_pc;
                    stage_q <= 32'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign stage       = stage_q;
    assign PC_readdata = pc_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_chip8_fetch_sequencer.sv
module tb_chip8_fetch_sequencer;

    logic        cpu_clk;
    logic        reset;
    logic        run;
    logic [11:0] mem_addr;
    logic [7:0]  mem_readdata;
    logic [15:0] instruction;
    logic [31:0] stage;
    logic        instr_done;
    logic [1:0]  pc_src;
    logic [11:0] PC_writedata;
    logic [11:0] PC_readdata;
    logic        halt_for_keypress;
    logic        key_pressed;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:4095];

    chip8_fetch_sequencer #(
        .PC_RESET   (12'h200),
        .MAX_STAGES (32'd8)
    ) dut (
        .cpu_clk           (cpu_clk),
        .reset             (reset),
        .run               (run),
        .mem_addr          (mem_addr),
        .mem_readdata      (mem_readdata),
        .instruction       (instruction),
        .stage             (stage),
        .instr_done        (instr_done),
        .pc_src            (pc_src),
        .PC_writedata      (PC_writedata),
        .PC_readdata       (PC_readdata),
        .halt_for_keypress (halt_for_keypress),
        .key_pressed       (key_pressed),
        .fault             (fault)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Synchronous memory: data for an address appears one cycle later.
    always @(posedge cpu_clk) mem_readdata <= mem[mem_addr];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH_HI and run=1; leaves at stage 1.
    task automatic fetch(input logic [11:0] a, input logic [15:0] op);
        logic [11:0] a1;
        a1 = a + 12'd1;
        check_eq("fetch_hi_addr", {20'd0, mem_addr}, {20'd0, a});
        check_eq("pc_at_fetch", {20'd0, PC_readdata}, {20'd0, a});
        @(negedge cpu_clk);
        check_eq("fetch_lo_addr", {20'd0, mem_addr}, {20'd0, a1});
        @(negedge cpu_clk);
        check_eq("latch_addr", {20'd0, mem_addr}, 32'd0);
        check_eq("latch_stage", stage, 32'd0);
        @(negedge cpu_clk);
        check_eq("instruction", {16'd0, instruction}, {16'd0, op});
        check_eq("stage1", stage, 32'd1);
        check_eq("exec_addr", {20'd0, mem_addr}, 32'd0);
        check_eq("exec_pc", {20'd0, PC_readdata}, {20'd0, a});
    endtask

    // Entered at stage 1; finishes at stage 2 and leaves in the next FETCH_HI.
    task automatic retire(input logic [1:0] src, input logic [11:0] wd);
        @(negedge cpu_clk);
        check_eq("stage2", stage, 32'd2);
        instr_done   = 1'b1;
        pc_src       = src;
        PC_writedata = wd;
        @(negedge cpu_clk);
        instr_done   = 1'b0;
        pc_src       = 2'd0;
        PC_writedata = 12'h000;
        @(negedge cpu_clk);
        check_eq("stage_cleared", stage, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'hA5 ^ i[7:0];
        mem[12'h200] = 8'h61; mem[12'h201] = 8'hF0;
        mem[12'h202] = 8'h12; mem[12'h203] = 8'h34;
        mem[12'h206] = 8'hA2; mem[12'h207] = 8'h2E;
        mem[12'h3A6] = 8'h00; mem[12'h3A7] = 8'hE0;
        mem[12'hFFE] = 8'hD0; mem[12'hFFF] = 8'h15;
        mem[12'h000] = 8'h6A; mem[12'h001] = 8'h02;
        mem[12'h004] = 8'hF2; mem[12'h005] = 8'h0A;

        reset             = 1'b1;
        run               = 1'b1;
        instr_done        = 1'b0;
        pc_src            = 2'd0;
        PC_writedata      = 12'h000;
        halt_for_keypress = 1'b0;
        key_pressed       = 1'b0;

        // Reset state
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        check_eq("rst_stage", stage, 32'd0);
        check_eq("rst_instr", {16'd0, instruction}, 32'd0);
        check_eq("rst_addr", {20'd0, mem_addr}, 32'd0);
        check_eq("rst_pc", {20'd0, PC_readdata}, 32'h200);
        check_eq("rst_fault", {31'd0, fault}, 32'd0);

        // Fetch issues immediately after reset release
        reset = 1'b0;
        #1;
        fetch(12'h200, 16'h61F0);
        retire(2'd0, 12'h000);            // +2
        fetch(12'h202, 16'h1234);
        retire(2'd1, 12'h000);            // skip: +4
        fetch(12'h206, 16'hA22E);
        retire(2'd2, 12'h3A6);            // jump
        fetch(12'h3A6, 16'h00E0);
        retire(2'd2, 12'hFFE);            // jump to top of memory
        fetch(12'hFFE, 16'hD015);
        retire(2'd0, 12'h000);            // 0xFFE+2 wraps to 0x000
        fetch(12'h000, 16'h6A02);
        retire(2'd1, 12'h000);            // 0x000+4
        fetch(12'h004, 16'hF20A);
        retire(2'd3, 12'h000);            // hold: same PC again
        fetch(12'h004, 16'hF20A);

        // Keypress halt at stage 3
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        check_eq("pre_halt_stage", stage, 32'd3);
        halt_for_keypress = 1'b1;
        key_pressed       = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge cpu_clk);
            check_eq("halt_stage", stage, 32'd3);
        end
        key_pressed = 1'b1;
        @(negedge cpu_clk);
        check_eq("key_stage", stage, 32'd4);
        halt_for_keypress = 1'b0;
        key_pressed       = 1'b0;
        @(negedge cpu_clk);
        check_eq("stage5", stage, 32'd5);

        // Reset mid-execute
        reset = 1'b1;
        @(negedge cpu_clk);
        check_eq("midrst_stage", stage, 32'd0);
        check_eq("midrst_pc", {20'd0, PC_readdata}, 32'h200);
        check_eq("midrst_instr", {16'd0, instruction}, 32'd0);
        check_eq("midrst_addr", {20'd0, mem_addr}, 32'd0);

        // run=0: no fetch issued
        run   = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge cpu_clk);
            check_eq("idle_addr", {20'd0, mem_addr}, 32'd0);
            check_eq("idle_stage", stage, 32'd0);
        end
        run = 1'b1;
        #1;
        fetch(12'h200, 16'h61F0);

        // Execute without instr_done
`ifdef CHIP8_FETCH_WATCHDOG_EN
        for (int i = 0; i < 7; i++) @(negedge cpu_clk);
        check_eq("wd_stage8", stage, 32'd8);
        check_eq("wd_fault_pre", {31'd0, fault}, 32'd0);
        @(negedge cpu_clk);
        check_eq("wd_fault", {31'd0, fault}, 32'd1);
        @(negedge cpu_clk);
        check_eq("wd_next_addr", {20'd0, mem_addr}, 32'h202);
        check_eq("wd_stage0", stage, 32'd0);
        check_eq("wd_fault_sticky", {31'd0, fault}, 32'd1);
`else
        for (int i = 0; i < 12; i++) @(negedge cpu_clk);
        check_eq("nowd_stage13", stage, 32'd13);
        check_eq("nowd_fault", {31'd0, fault}, 32'd0);
        check_eq("nowd_addr", {20'd0, mem_addr}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chip8_fetch_sequencer.md
# chip8_fetch_sequencer

Instruction fetch and stage sequencer that drives the Chip8_CPU execution interface. It owns the program counter, fetches the two-byte big-endian opcode from main memory, presents `instruction` and a monotonically increasing `stage` count to the CPU, and applies the CPU's PC update request when the instruction completes. It sits between the memory arbiter and Chip8_CPU inside the Chip8 top level.

## Interface
Parameters:
- `PC_RESET`, 12'h200, PC value after reset.
- `MAX_STAGES`, 32'd64, watchdog limit on execute length; used only with `CHIP8_FETCH_WATCHDOG_EN`.

Ports:
- `cpu_clk` in 1: single clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: when low, the sequencer finishes the current instruction and then idles in FETCH_HI without issuing a fetch.
- `mem_addr` out 12: fetch byte address.
- `mem_readdata` in 8: memory data, valid one cycle after `mem_addr`.
- `instruction` out 16: current opcode, `{hi, lo}`.
- `stage` out 32: 0 outside execute; 1, 2, 3, … during execute.
- `instr_done` in 1: CPU marks the final execute stage.
- `pc_src` in 2: sampled with `instr_done`. 0 = next (+2), 1 = skip (+4), 2 = load `PC_writedata`, 3 = hold (re-fetch the same PC).
- `PC_writedata` in 12: jump target for `pc_src`=2.
- `PC_readdata` out 12: current PC (address of the executing instruction).
- `halt_for_keypress` in 1: CPU is waiting for a key.
- `key_pressed` in 1: keypad has a key down.
- `fault` out 1: watchdog trip flag. Always 0 when the macro is off.

## Operation
- States: FETCH_HI, FETCH_LO, LATCH, EXECUTE, UPDATE_PC.
- **FETCH_HI**: if `run`=1, drive `mem_addr`=PC, then go to FETCH_LO. Otherwise stay in FETCH_HI.
- **FETCH_LO**: drive `mem_addr`=PC+1 (mod 4096), capture `mem_readdata` as the high byte, then go to LATCH.
- **LATCH**: capture the low byte, update `instruction`, set `stage`=1, then go to EXECUTE.
- **EXECUTE**: `stage` increments by 1 per cycle.
  - If `halt_for_keypress`=1 and `key_pressed`=0, `stage` freezes.
  - If `instr_done`=1, register `pc_src` and `PC_writedata`, then go to UPDATE_PC.
  - `instr_done` overrides a halt in the same cycle.
- **UPDATE_PC**: apply the registered request, set `stage`=0, then go to FETCH_HI.
- PC arithmetic is 12-bit and wraps: 0xFFE+2 = 0x000; 0xFFE+4 = 0x002.
- `instruction` stays stable from LATCH until the next LATCH. The CPU may read it in every stage.
- `mem_addr` is 0 in LATCH, EXECUTE and UPDATE_PC, so the CPU owns the memory port during execute.
- The 32-bit `stage` counter saturates at 32'hFFFF_FFFF; it does not wrap.

## Timing
- Reset values: PC=`PC_RESET`, state=FETCH_HI, `instruction`=16'h0000, `stage`=0, `mem_addr`=0, `fault`=0.
- `reset` taken in any state, including mid-execute, aborts the instruction immediately. The first fetch issues on the cycle after `reset` deasserts, provided `run`=1.
- Fetch latency: 3 cycles from entering FETCH_HI to `stage`=1.
- Minimum instruction period: 3 fetch cycles + n execute cycles + 1 UPDATE_PC cycle.
- `PC_readdata` updates in the cycle after UPDATE_PC. It is constant for the whole execute phase.

## Configuration
- `CHIP8_FETCH_WATCHDOG_EN` defined:
  - If `stage` reaches `MAX_STAGES` in EXECUTE without `instr_done`, a keypress halt excepted, the sequencer forces UPDATE_PC with pc_src=0 and sets `fault`=1.
  - `fault` is sticky until `reset`.
- Not defined:
  - No watchdog. `fault` is tied to 0.
  - `MAX_STAGES` is ignored.

## Test plan
- Reset, `run`=1, memory [0x200]=0x61, [0x201]=0xF0 -> `mem_addr` 0x200 then 0x201; `instruction`=16'h61F0 and `stage`=1 on the 3rd cycle; `PC_readdata`=0x200.
- `instr_done` at stage 2 with pc_src=0 -> `stage` returns to 0; next fetch at 0x202. With pc_src=1 -> next fetch at 0x204.
- pc_src=2, `PC_writedata`=0x3A6 -> next fetch at 0x3A6/0x3A7. With PC=0xFFE and pc_src=0 -> next fetch at 0x000.
- `halt_for_keypress`=1, `key_pressed`=0 at stage 3 for 10 cycles -> `stage` holds 3. Then `key_pressed`=1 -> `stage` 4 on the next cycle.
- `reset` pulsed at stage 5 -> next cycle `stage`=0, PC=0x200, `instruction`=0. `run`=0 -> no fetch addresses issued.
- With `CHIP8_FETCH_WATCHDOG_EN`, `MAX_STAGES`=8, `instr_done` never asserted -> `fault`=1 after stage 8; next fetch at PC+2. Without the macro -> `stage` keeps counting and `fault`=0.
